// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg -- shared definitions for the pipeline hazard controller.
//   state_t          : hazard FSM state encoding (RUN, LD_STALL, BR_FLUSH, MEM_WAIT)
//   REG_IDX_W        : width of a register index
//   MAX_WAIT_DEFAULT : default number of mem_busy cycles tolerated before timeout
package mips_pipe_pkg;

    localparam int REG_IDX_W        = 5;
    localparam int MAX_WAIT_DEFAULT = 15;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_BR_FLUSH = 2'd2,
        ST_MEM_WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect -- combinational load-use hazard detector.
// Ports:
//   id_rs, id_rt  : source register indices of the instruction in ID
//   id_uses_rt    : ID instruction reads rt as a source
//   ex_rt         : destination register of the instruction in EX
//   ex_memread    : EX instruction is a load
//   load_use      : ID needs the value the EX load has not yet produced
module hazard_detect
    import mips_pipe_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rt,
    input  logic [REG_IDX_W-1:0] ex_rt,
    input  logic                 ex_memread,
    output logic                 load_use
);

    // Register 0 is hard-wired to zero, so a load targeting it never
    // creates a dependency.
    assign load_use = ex_memread && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- stall/flush controller for a 5-stage MIPS pipeline.
// Configuration macro: PIPE_HAZARD_PERF_EN enables the stall/flush
// performance counters; without it both counter ports read 0.
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   id_rs, id_rt, id_uses_rt  : source operands of the ID instruction
//   ex_rt, ex_memread         : destination / load flag of the EX instruction
//   branch_taken              : branch resolved taken in MEM
//   mem_busy                  : data memory not ready this cycle
//   pc_en, ifid_en, idex_en   : pipeline register write enables
//   ifid_flush, idex_flush    : insert a bubble into IF_ID / ID_EX
//   state_out                 : current FSM state
//   timeout                   : sticky, memory stayed busy for MAX_WAIT cycles
//   stall_cnt, flush_cnt      : saturating performance counters
// Handshake: none; every output is a level decoded from the current state
// and this cycle's inputs, and is sampled by the pipeline at the rising edge.
// Decode priority: mem_busy > branch_taken > load-use.
module pipe_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rt,
    input  logic [REG_IDX_W-1:0] ex_rt,
    input  logic                 ex_memread,
    input  logic                 branch_taken,
    input  logic                 mem_busy,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic [1:0]           state_out,
    output logic                 timeout,
    output logic [15:0]          stall_cnt,
    output logic [15:0]          flush_cnt
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                wait_hit;
    logic                timeout_q;
    logic                load_use;
    logic                lu_allowed;

    hazard_detect u_hazard_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_rt      (ex_rt),
        .ex_memread (ex_memread),
        .load_use   (load_use)
    );

    // The cycle right after a stall or flush already has the hazard resolved,
    // so load-use detection is masked there.
    assign lu_allowed = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        state_d    = ST_RUN;
        wait_d     = '0;
        wait_hit   = 1'b0;
        if (!rst) begin
            // Outputs fall to their reset values as soon as reset asserts.
            state_d = ST_RUN;
        end else if (mem_busy) begin
            // Freeze the whole pipeline; give up waiting after MAX_WAIT cycles
            // but keep the enables low for as long as memory stays busy.
            if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                wait_hit = 1'b1;
                state_d  = ST_RUN;
            end else begin
                wait_d  = wait_q + 1'b1;
                state_d = ST_MEM_WAIT;
            end
        end else if (branch_taken) begin
            // Wrong-path instructions are squashed; flush overrides enable.
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = ST_BR_FLUSH;
        end else if (load_use && lu_allowed) begin
            // Hold PC and IF_ID, push a bubble into ID_EX.
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            state_d    = ST_LD_STALL;
        end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
            idex_en = 1'b1;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (wait_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign state_out = state_q;
    assign timeout   = timeout_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (ifid_flush && (flush_q != 16'hFFFF)) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl -- self-checking bench for pipe_hazard_ctrl.
// Expected values come from a behavioural model of the hazard rules kept
// below (event classification per cycle, consecutive-busy streak, counters).
module tb_pipe_hazard_ctrl;

    localparam int MAX_WAIT = 15;
`ifdef PIPE_HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_memread, branch_taken, mem_busy;
    logic        pc_en, ifid_en, idex_en, ifid_flush, idex_flush;
    logic [1:0]  state_out;
    logic        timeout;
    logic [15:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model
    int m_state;    // what the previous cycle did: 0 normal, 1 load stall, 2 branch flush, 3 memory wait
    int m_streak;   // consecutive busy cycles since the last timeout / release
    bit m_timeout;
    int m_stall;
    int m_flush;

    pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_rt        (ex_rt),
        .ex_memread   (ex_memread),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .state_out    (state_out),
        .timeout      (timeout),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_state   = 0;
        m_streak  = 0;
        m_timeout = 1'b0;
        m_stall   = 0;
        m_flush   = 0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pc_en"},   32'(pc_en), 0);
        chk({tag, "_ifid_en"}, 32'(ifid_en), 0);
        chk({tag, "_idex_en"}, 32'(idex_en), 0);
        chk({tag, "_flushes"}, 32'({ifid_flush, idex_flush}), 0);
        chk({tag, "_state"},   32'(state_out), 0);
        chk({tag, "_timeout"}, 32'(timeout), 0);
        chk({tag, "_stall"},   32'(stall_cnt), 0);
        chk({tag, "_flush"},   32'(flush_cnt), 0);
    endtask

    // Called just after a rising edge: applies inputs, checks at the falling
    // edge, then advances the model across the next rising edge.
    task automatic cycle(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic [4:0] ert, input logic mr, input logic br,
                         input logic busy);
        bit lu;
        int e_pc, e_ifid, e_idex, e_iff, e_idf, nxt;
        id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_rt = ert; ex_memread = mr; branch_taken = br; mem_busy = busy;
        lu = mr && (ert != 0) && (ert == rs || (urt && ert == rt)) &&
             !(m_state == 1 || m_state == 2);
        e_pc = 0; e_ifid = 0; e_idex = 0; e_iff = 0; e_idf = 0; nxt = 0;
        if (busy) begin
            m_streak++;
            if (m_streak == MAX_WAIT) begin
                m_streak = 0;
                nxt = 0;
            end else begin
                nxt = 3;
            end
        end else begin
            m_streak = 0;
            if (br) begin
                e_pc = 1; e_ifid = 1; e_idex = 1; e_iff = 1; e_idf = 1; nxt = 2;
            end else if (lu) begin
                e_idex = 1; e_idf = 1; nxt = 1;
            end else begin
                e_pc = 1; e_ifid = 1; e_idex = 1; nxt = 0;
            end
        end
        @(negedge clk);
        chk("pc_en",      32'(pc_en),      32'(e_pc));
        chk("ifid_en",    32'(ifid_en),    32'(e_ifid));
        chk("idex_en",    32'(idex_en),    32'(e_idex));
        chk("ifid_flush", 32'(ifid_flush), 32'(e_iff));
        chk("idex_flush", 32'(idex_flush), 32'(e_idf));
        chk("state",      32'(state_out),  32'(m_state));
        chk("timeout",    32'(timeout),    32'(m_timeout));
        chk("stall_cnt",  32'(stall_cnt),  PERF ? 32'(m_stall) : 0);
        chk("flush_cnt",  32'(flush_cnt),  PERF ? 32'(m_flush) : 0);
        @(posedge clk);
        #1;
        if (busy && nxt == 0) m_timeout = 1'b1;
        if (e_pc == 0 && m_stall < 65535) m_stall++;
        if (e_iff == 1 && m_flush < 65535) m_flush++;
        m_state = nxt;
    endtask

    task automatic idle();
        cycle(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int burst;
        // clock/reset
        rst = 1'b0;
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_rt = '0;
        ex_memread = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
        model_clear();
        #2;
        chk_reset_values("por");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // load-use on rs: one stall cycle, then a normal cycle
        idle();
        cycle(5'd8, 5'd9, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        cycle(5'd8, 5'd9, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        idle();
        // load-use on rt only when rt is a source
        cycle(5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        cycle(5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        // load to r0 never stalls
        cycle(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        // branch wins over a simultaneous load-use
        cycle(5'd4, 5'd5, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
        cycle(5'd4, 5'd5, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        // branch honoured inside LD_STALL
        cycle(5'd6, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        cycle(5'd6, 5'd5, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
        idle();
        // short memory wait, then release with a load-use pending
        for (int i = 0; i < 3; i++) cycle(5'd8, 5'd9, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1);
        cycle(5'd8, 5'd9, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        idle();
        // long memory wait: timeout after MAX_WAIT busy cycles, sticky
        for (int i = 0; i < 16; i++) idle_busy();
        for (int i = 0; i < 4; i++) idle();

        // asynchronous reset in the middle of a load stall
        cycle(5'd8, 5'd9, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk_reset_values("rst_mid_stall");
        model_clear();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        cycle(5'd8, 5'd9, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        idle();

        // randomized traffic with occasional memory bursts
        burst = 0;
        for (int i = 0; i < 600; i++) begin
            logic busy_now;
            if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(1, 20);
            busy_now = (burst != 0);
            if (burst != 0) burst--;
            cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0), busy_now);
        end

        // final reset clears the sticky timeout
        rst = 1'b0;
        #1;
        chk_reset_values("final_rst");
        model_clear();
        @(posedge clk); #1;
        rst = 1'b1;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic idle_busy();
        cycle(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
    endtask

    // hard stop if the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15: mem_busy cycles tolerated before timeout.
REQ-002 Port clk  in  1  pipeline clock; all state changes on its rising edge.
REQ-003 Port rst  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port id_rs  in  5  rs index of the instruction in ID.
REQ-005 Port id_rt  in  5  rt index of the instruction in ID.
REQ-006 Port id_uses_rt  in  1  ID instruction reads rt as a source.
REQ-007 Port ex_rt  in  5  destination rt of the instruction in EX (ID_EX rt_out).
REQ-008 Port ex_memread  in  1  EX instruction is a load (ID_EX MemRead_out).
REQ-009 Port branch_taken  in  1  branch resolved taken in MEM.
REQ-010 Port mem_busy  in  1  data memory not ready this cycle.
REQ-011 Port pc_en, ifid_en, idex_en  out  1 each  write enables for PC, IF_ID, ID_EX.
REQ-012 Port ifid_flush, idex_flush  out  1 each  force bubble (all control fields 0) into IF_ID / ID_EX.
REQ-013 Port state_out  out  2  current FSM state encoding.
REQ-014 Port timeout  out  1  sticky: mem_busy exceeded MAX_WAIT.
REQ-015 Port stall_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-016 FSM states SHALL be RUN=0, LD_STALL=1, BR_FLUSH=2, MEM_WAIT=3.
REQ-017 Output decode SHALL be combinational from state and inputs; priority mem_busy > branch_taken > load-use.
REQ-018 Load-use hazard SHALL be: ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
REQ-019 RUN, no event: pc_en=ifid_en=idex_en=1, both flushes 0, next RUN.
REQ-020 Any state, mem_busy=1: all enables 0, flushes 0, next MEM_WAIT, wait counter +1.
REQ-021 MEM_WAIT with mem_busy=0: wait counter cleared, normal RUN decode this cycle.
REQ-022 Wait counter reaching MAX_WAIT: timeout set (sticky until reset), counter cleared, next RUN; enables stay 0 while mem_busy remains high.
REQ-023 branch_taken (no busy): pc_en=1, ifid_flush=idex_flush=1, next BR_FLUSH; simultaneous load-use ignored.
REQ-024 Load-use (no busy, no branch): pc_en=ifid_en=0, idex_en=1, idex_flush=1, next LD_STALL.
REQ-025 LD_STALL and BR_FLUSH SHALL each last exactly one cycle and suppress load-use detection; branch_taken in them is still honoured.
REQ-026 Flush SHALL dominate enable: ifid_flush=1 implies ifid_en=1.

Reset
REQ-027 While rst=0: state RUN, all enables 0, flushes 0, wait counter 0, timeout 0, counters 0.
REQ-028 Reset asserted mid-stall SHALL abort it; first cycle after release is RUN.

Configuration
REQ-029 With PIPE_HAZARD_PERF_EN defined: stall_cnt increments each cycle pc_en=0, flush_cnt each cycle ifid_flush=1, both saturating at 16'hFFFF.
REQ-030 Without PIPE_HAZARD_PERF_EN: ports stall_cnt, flush_cnt remain, tied to 0; no counter flops.

Structure
REQ-031 Package mips_pipe_pkg SHALL hold the state enum, REG_IDX_W=5, and MAX_WAIT default.
REQ-032 Sub-module hazard_detect SHALL implement REQ-018 combinationally; FSM, counters in top.

Verification
REQ-033 ex_memread=1, ex_rt=8, id_rs=8 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle RUN all enables 1.
REQ-034 ex_memread=1, ex_rt=0, id_rs=0 -> no stall.
REQ-035 branch_taken=1 with load-use true -> ifid_flush=idex_flush=1, pc_en=1, state BR_FLUSH, no LD_STALL.
REQ-036 mem_busy high 3 cycles -> enables 0 for 3 cycles, timeout 0; released -> RUN.
REQ-037 mem_busy high 16 cycles, MAX_WAIT=15 -> timeout=1 and stays 1 until rst=0.
REQ-038 rst=0 asserted during LD_STALL -> outputs immediately at reset values; PIPE_HAZARD_PERF_EN build: stall_cnt=0 after release.
